// File: rtl/shift_register_seq.sv
// Parametrised shift/rotate register with a burst sequencer that repeats the
// selected operation Count times and pulses Done when the burst completes.
module shift_register_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [2:0]       Mode,
  input  logic             LeftInput,
  input  logic             RightInput,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] out,
  output logic             SerialOut,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state,     w_stateNext;
  logic [WIDTH-1:0] r_out,       w_outNext;
  logic             r_serial,    w_serialNext;
  logic             r_busy,      w_busyNext;
  logic             r_done,      w_doneNext;
  logic [2:0]       r_mode,      w_modeNext;
  logic [CNT_W-1:0] r_remaining, w_remainingNext;

  logic [2:0]       w_opMode;
  logic [WIDTH-1:0] w_opOut;
  logic             w_opSerial;

  // Datapath for one operation; a burst uses the mode captured at Start.
  always_comb begin
    w_opMode   = (r_state == RUN) ? r_mode : Mode;
    w_opOut    = r_out;
    w_opSerial = r_serial;
    case (w_opMode)
      3'b001: begin
        w_opOut    = {LeftInput, r_out[WIDTH-1:1]};
        w_opSerial = r_out[0];
      end
      3'b010: begin
        w_opOut    = {r_out[WIDTH-2:0], RightInput};
        w_opSerial = r_out[WIDTH-1];
      end
      3'b011: begin
        w_opOut    = {r_out[0], r_out[WIDTH-1:1]};
        w_opSerial = r_out[0];
      end
      3'b100: begin
        w_opOut    = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
        w_opSerial = r_out[WIDTH-1];
      end
      3'b101: begin
        w_opOut    = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
        w_opSerial = r_out[0];
      end
      default: begin
        w_opOut    = r_out;
        w_opSerial = r_serial;
      end
    endcase
  end

  always_comb begin
    w_stateNext     = r_state;
    w_outNext       = r_out;
    w_serialNext    = r_serial;
    w_busyNext      = r_busy;
    w_doneNext      = 1'b0;
    w_modeNext      = r_mode;
    w_remainingNext = r_remaining;

    if (Enable) begin
      if (Load) begin
        w_outNext   = DataIn;
        w_stateNext = IDLE;
        w_busyNext  = 1'b0;
      end else if (r_state == IDLE) begin
        if (Start) begin
          w_modeNext      = Mode;
          w_remainingNext = Count;
          if (Count != '0) begin
            w_stateNext = RUN;
            w_busyNext  = 1'b1;
          end else begin
            w_doneNext = 1'b1;
          end
        end else begin
          w_outNext    = w_opOut;
          w_serialNext = w_opSerial;
        end
      end else begin
        w_outNext    = w_opOut;
        w_serialNext = w_opSerial;
        if (r_remaining != '0) begin
          w_remainingNext = r_remaining - CNT_W'(1);
        end
        // Remaining count saturates at zero; the edge consuming the last op ends the burst.
        if (r_remaining <= CNT_W'(1)) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_serial    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mode      <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_out       <= w_outNext;
      r_serial    <= w_serialNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
      r_mode      <= w_modeNext;
      r_remaining <= w_remainingNext;
    end
  end

  assign out       = r_out;
  assign SerialOut = r_serial;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed self-checking bench for shift_register_seq (WIDTH=4, CNT_W=3).
module tb_shift_register_seq;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Load;
  logic [3:0] DataIn;
  logic [2:0] Mode;
  logic       LeftInput;
  logic       RightInput;
  logic       Start;
  logic [2:0] Count;
  logic [3:0] out;
  logic       SerialOut;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  shift_register_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load),
    .DataIn(DataIn), .Mode(Mode), .LeftInput(LeftInput),
    .RightInput(RightInput), .Start(Start), .Count(Count),
    .out(out), .SerialOut(SerialOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [3:0] din,
                               input logic [2:0] md, input logic st, input logic [2:0] cnt);
    Enable = en; Load = ld; DataIn = din; Mode = md; Start = st; Count = cnt;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    LeftInput = 1'b0; RightInput = 1'b0;
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'b1111, 3'b000, 1'b0, 3'd0);
    step(); step();
    checkOutput("rst_out", out, 4'b0000);
    checkOutput("rst_so", SerialOut, 1'b0);
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_done", Done, 1'b0);
    Reset = 1'b0;

    // Logical shift right with LeftInput fill
    applyStimulus(1'b1, 1'b1, 4'b1010, 3'b000, 1'b0, 3'd0);
    step();
    checkOutput("load_1010", out, 4'b1010);
    Load = 1'b0; Mode = 3'b001; LeftInput = 1'b1;
    step(); checkOutput("lsr1_out", out, 4'b1101); checkOutput("lsr1_so", SerialOut, 1'b0);
    step(); checkOutput("lsr2_out", out, 4'b1110); checkOutput("lsr2_so", SerialOut, 1'b1);
    step(); checkOutput("lsr3_out", out, 4'b1111); checkOutput("lsr3_so", SerialOut, 1'b0);
    LeftInput = 1'b0;

    // Rotate-left burst, live Mode change ignored
    applyStimulus(1'b1, 1'b1, 4'b0011, 3'b000, 1'b0, 3'd0);
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b100, 1'b1, 3'd3);
    step();
    checkOutput("rol_e0_out", out, 4'b0011);
    checkOutput("rol_e0_busy", Busy, 1'b1);
    checkOutput("rol_e0_done", Done, 1'b0);
    Start = 1'b0; Mode = 3'b000;
    step(); checkOutput("rol_e1_out", out, 4'b0110); checkOutput("rol_e1_busy", Busy, 1'b1);
    step(); checkOutput("rol_e2_out", out, 4'b1100); checkOutput("rol_e2_done", Done, 1'b0);
    step(); checkOutput("rol_e3_out", out, 4'b1001);
    checkOutput("rol_e3_busy", Busy, 1'b0);
    checkOutput("rol_e3_done", Done, 1'b1);
    step(); checkOutput("rol_hold_out", out, 4'b1001); checkOutput("rol_done_clr", Done, 1'b0);

    // Arithmetic shift right burst, then zero-length burst
    applyStimulus(1'b1, 1'b1, 4'b1000, 3'b000, 1'b0, 3'd0);
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b101, 1'b1, 3'd2);
    step();
    Start = 1'b0; Mode = 3'b000;
    step(); checkOutput("asr1_out", out, 4'b1100); checkOutput("asr1_so", SerialOut, 1'b0);
    step(); checkOutput("asr2_out", out, 4'b1110); checkOutput("asr2_so", SerialOut, 1'b0);
    checkOutput("asr2_done", Done, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b001, 1'b1, 3'd0);
    step();
    checkOutput("cnt0_done", Done, 1'b1);
    checkOutput("cnt0_busy", Busy, 1'b0);
    checkOutput("cnt0_out", out, 4'b1110);
    Start = 1'b0; Enable = 1'b0;
    step();
    checkOutput("cnt0_done_clr_stall", Done, 1'b0);
    checkOutput("cnt0_busy2", Busy, 1'b0);

    // Shift-left burst with an Enable stall
    applyStimulus(1'b1, 1'b1, 4'b0001, 3'b000, 1'b0, 3'd0);
    RightInput = 1'b0;
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b010, 1'b1, 3'd2);
    step();
    Start = 1'b0; Mode = 3'b000;
    step(); checkOutput("sl1_out", out, 4'b0010);
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_out", out, 4'b0010);
      checkOutput("stall_busy", Busy, 1'b1);
    end
    Enable = 1'b1;
    step();
    checkOutput("sl2_out", out, 4'b0100);
    checkOutput("sl2_done", Done, 1'b1);
    checkOutput("sl2_busy", Busy, 1'b0);

    // Maximum burst length (7 rotate-rights)
    applyStimulus(1'b1, 1'b1, 4'b0001, 3'b000, 1'b0, 3'd0);
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b011, 1'b1, 3'd7);
    step();
    Start = 1'b0; Mode = 3'b000;
    for (int i = 0; i < 6; i++) step();
    checkOutput("max6_out", out, 4'b0100);
    checkOutput("max6_busy", Busy, 1'b1);
    checkOutput("max6_done", Done, 1'b0);
    step();
    checkOutput("max7_out", out, 4'b0010);
    checkOutput("max7_done", Done, 1'b1);
    checkOutput("max7_busy", Busy, 1'b0);

    // Load aborts a burst
    applyStimulus(1'b1, 1'b1, 4'b0001, 3'b000, 1'b0, 3'd0);
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b010, 1'b1, 3'd5);
    step();
    Start = 1'b0; Mode = 3'b000;
    step(); checkOutput("abort_sl1", out, 4'b0010);
    Load = 1'b1; DataIn = 4'b0110;
    step();
    checkOutput("abort_out", out, 4'b0110);
    checkOutput("abort_busy", Busy, 1'b0);
    checkOutput("abort_done", Done, 1'b0);
    Load = 1'b0;
    step();
    checkOutput("abort_out2", out, 4'b0110);
    checkOutput("abort_done2", Done, 1'b0);

    // Reset mid-burst
    applyStimulus(1'b1, 1'b0, 4'b0000, 3'b010, 1'b1, 3'd5);
    step();
    Start = 1'b0;
    step(); checkOutput("prerst_out", out, 4'b1100);
    Reset = 1'b1;
    step();
    checkOutput("midrst_out", out, 4'b0000);
    checkOutput("midrst_so", SerialOut, 1'b0);
    checkOutput("midrst_busy", Busy, 1'b0);
    checkOutput("midrst_done", Done, 1'b0);
    Reset = 1'b0; Mode = 3'b001; LeftInput = 1'b1;
    step();
    checkOutput("postrst_idle_out", out, 4'b1000);
    checkOutput("postrst_busy", Busy, 1'b0);
    checkOutput("postrst_done", Done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_register_seq.md
Name: shift_register_seq

Overview:
Parametrised successor to the team's 4-bit shift register. It adds generic width and a full mode set: shift, rotate, arithmetic shift and parallel load. It also adds a programmable burst sequencer that applies the selected operation N times and then pulses Done. It serves as the shifting datapath element for serialisers and for multi-step shift operations in the lab processor.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, burst-count width; max burst length 2^CNT_W-1

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Enable  input  1  global clock enable; low = full stall
Load  input  1  parallel load of DataIn
DataIn  input  WIDTH  parallel load data
Mode  input  3  operation select (see Behaviour)
LeftInput  input  1  serial fill bit entering the MSB on logical shift right
RightInput  input  1  serial fill bit entering the LSB on shift left
Start  input  1  request a burst of Count operations
Count  input  CNT_W  burst length
out  output  WIDTH  register contents
SerialOut  output  1  last bit shifted or rotated out
Busy  output  1  burst in progress
Done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock (Clock). Reset is synchronous and active-high.
- Reset values: all outputs 0 (out, SerialOut, Busy, Done); FSM to IDLE; latched mode and remaining count to 0.
- Mode encoding:
  - 000 hold
  - 001 logical shift right: out <= {LeftInput, out[W-1:1]}
  - 010 shift left: out <= {out[W-2:0], RightInput}
  - 011 rotate right
  - 100 rotate left
  - 101 arithmetic shift right (MSB replicated)
  - 110 and 111 hold
- SerialOut: registered; updated only on a shift or rotate edge.
  - Right ops: SerialOut <= out[0] (old value).
  - Left ops: SerialOut <= out[W-1] (old value).
  - Otherwise holds.
- Priority, evaluated each rising edge: Reset > Enable=0 (nothing changes except Done clears) > Load > Start > operation.
- Load (Enable=1): out <= DataIn in any state.
  - In RUN, Load aborts the burst: FSM to IDLE, Busy <= 0, no Done pulse.
  - SerialOut unchanged.
- FSM states: IDLE, RUN.
- IDLE, single-step: each Enable cycle applies the live Mode once; one-edge latency.
- IDLE, Start=1 with Enable=1 and no Load: Start is accepted.
  - Mode is latched and remaining count <= Count.
  - No operation is applied on the acceptance edge.
  - Count != 0: go to RUN, Busy <= 1.
  - Count == 0: stay IDLE, Busy stays 0, Done <= 1 on the acceptance edge.
- RUN: each Enable=1 edge applies the latched Mode and decrements the remaining count.
  - The edge that applies the final operation sets Busy <= 0 and Done <= 1, and returns the FSM to IDLE.
  - Live Mode changes are ignored in RUN.
  - Start is ignored in RUN.
- Done: high for exactly one cycle, then cleared on the next edge, even if Enable=0.
- Enable=0 during RUN: out, count and Busy freeze; the burst resumes when Enable returns.
- Reset mid-burst: immediate return to reset values; no Done pulse.
- Count of 2^CNT_W-1 is supported. No wrap of the internal count is permitted: it stops at 0.

Test Plan:
1. Assert Reset 2 cycles, with Enable=1 and Load=1, DataIn=1111 -> out=0000, SerialOut=0, Busy=0, Done=0 (Reset beats Load).
2. Load 1010; Mode=001, LeftInput=1, 3 edges -> out 1101, 1110, 1111; SerialOut 0, 1, 0.
3. Load 0011; Start with Count=3, Mode=100 at edge E0, Mode changed to 000 at E1 -> out 0110, 1100, 1001 at E1, E2, E3. Busy=1 from E0 to E3, Done=1 only after E3, then out holds at 1001.
4. Load 1000; Start with Count=2, Mode=101 -> out 1100 then 1110, SerialOut 0. Separately, Start with Count=0 -> Done pulses one cycle, Busy never rises, out unchanged.
5. Load 0001; Start with Count=2, Mode=010, RightInput=0; drop Enable for 3 cycles after the first shift -> out holds at 0010 and Busy stays 1; after Enable returns, out=0100 and Done pulses.
6. During a Count=5 burst:
   - Load 0110 at the 2nd shift -> out=0110, Busy=0, no Done.
   - Repeat the burst with Reset mid-run -> all outputs 0, FSM IDLE.
